// File: rtl/bit_sampler_deframer.sv
// Mid-bit sampler and sync-byte deframer for a raw serial line on the 200 MHz base clock.
// Re-phases on every synchronised input edge; MSB-first bytes are emitted once locked.
`timescale 1ns/1ps
module bit_sampler_deframer #(
  parameter int          PERIOD_W   = 16,
  parameter logic [7:0]  SYNC_WORD  = 8'hA5,
  parameter int          MIN_PERIOD = 4,
  parameter int          MAX_RUN    = 32
) (
  input  logic                clk_200M,
  input  logic                rst_n,
  input  logic                signal,
  input  logic [PERIOD_W-1:0] bit_period,
  output logic                bit_out,
  output logic                bit_valid,
  output logic [7:0]          data_out,
  output logic                data_valid,
  output logic                locked,
  output logic                sync_err
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_r, state_nx;
  logic                sig_m_r, sig_s_r, sig_d_r;
  logic [PERIOD_W-1:0] period_r, phase_r, phase_nx;
  logic [7:0]          shift_r, shift_nx;
  logic [2:0]          bit_cnt_r, bit_cnt_nx;
  logic [RUN_W-1:0]    run_cnt_r, run_cnt_nx;
  logic                edge_s, valid_s, wrap_s, sample_s;
  logic                data_valid_nx, sync_err_nx;

  assign edge_s   = sig_s_r ^ sig_d_r;
  assign valid_s  = (period_r >= PERIOD_W'(MIN_PERIOD));
  // An edge always wins over wrap or sample in the same cycle.
  assign wrap_s   = valid_s && !edge_s && (phase_r == (period_r - PERIOD_W'(1)));
  assign sample_s = valid_s && !edge_s && (phase_r == (period_r >> 1));
  assign shift_nx = {shift_r[6:0], sig_s_r};

  // Phase counter next value
  always_comb begin
    phase_nx = phase_r;
    if (edge_s || !valid_s || wrap_s) begin
      phase_nx = PERIOD_W'(0);
    end else begin
      phase_nx = phase_r + PERIOD_W'(1);
    end
  end

  // Framing FSM next state and pulse outputs
  always_comb begin
    state_nx      = state_r;
    bit_cnt_nx    = bit_cnt_r;
    run_cnt_nx    = run_cnt_r;
    data_valid_nx = 1'b0;
    sync_err_nx   = 1'b0;
    case (state_r)
      HUNT: begin
        if (sample_s && (shift_nx == SYNC_WORD)) begin
          state_nx   = LOCKED;
          bit_cnt_nx = 3'd0;
          run_cnt_nx = RUN_W'(0);
        end else begin
          state_nx   = HUNT;
        end
      end
      LOCKED: begin
        if (edge_s) begin
          run_cnt_nx = RUN_W'(0);
        end else if (wrap_s) begin
          run_cnt_nx = run_cnt_r + RUN_W'(1);
        end else begin
          run_cnt_nx = run_cnt_r;
        end
        if (sample_s) begin
          bit_cnt_nx = bit_cnt_r + 3'd1;
        end else begin
          bit_cnt_nx = bit_cnt_r;
        end
        // Loss of lock suppresses a byte completing in the same cycle.
        if (!valid_s || (run_cnt_nx == RUN_W'(MAX_RUN))) begin
          state_nx    = HUNT;
          sync_err_nx = 1'b1;
        end else if (sample_s && (bit_cnt_r == 3'd7) && (shift_nx != SYNC_WORD)) begin
          data_valid_nx = 1'b1;
        end else begin
          data_valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx = HUNT;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      sig_m_r    <= 1'b0;
      sig_s_r    <= 1'b0;
      sig_d_r    <= 1'b0;
      period_r   <= PERIOD_W'(0);
      phase_r    <= PERIOD_W'(0);
      shift_r    <= 8'd0;
      bit_cnt_r  <= 3'd0;
      run_cnt_r  <= RUN_W'(0);
      state_r    <= HUNT;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sig_m_r    <= signal;
      sig_s_r    <= sig_m_r;
      sig_d_r    <= sig_s_r;
      if (edge_s) begin
        period_r <= bit_period;
      end
      phase_r    <= phase_nx;
      if (sample_s) begin
        shift_r  <= shift_nx;
        bit_out  <= sig_s_r;
      end
      bit_valid  <= sample_s;
      bit_cnt_r  <= bit_cnt_nx;
      run_cnt_r  <= run_cnt_nx;
      state_r    <= state_nx;
      locked     <= (state_nx == LOCKED);
      data_valid <= data_valid_nx;
      if (data_valid_nx) begin
        data_out <= shift_nx;
      end
      sync_err   <= sync_err_nx;
    end
  end

endmodule
